// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared types and helpers.
// FSM states, width codes and byte lane helpers.
package mem_ctrl_pkg;

  localparam int AddrLen = 32;
  localparam int RegLen  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd4;

  // Any unsupported width code becomes a full word.
  function automatic logic [2:0] norm_width(input logic [2:0] w);
    if (w == W_BYTE || w == W_HALF) return w;
    return W_WORD;
  endfunction

  function automatic logic [7:0] get_byte(
    input logic [RegLen-1:0] w,
    input logic [2:0]        k
  );
    return w[{k[1:0], 3'b000} +: 8];
  endfunction

  function automatic logic [RegLen-1:0] set_byte(
    input logic [RegLen-1:0] w,
    input logic [2:0]        k,
    input logic [7:0]        b
  );
    logic [RegLen-1:0] r;
    r = w;
    r[{k[1:0], 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl bus bundle.
// Fetch port, MEM-stage port and byte-wide RAM port.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic               if_needed;
  logic [AddrLen-1:0] if_addr;
  logic               if_rdy;
  logic               if_busy;
  logic [RegLen-1:0]  if_data;

  logic               mem_needed;
  logic [AddrLen-1:0] mem_addr;
  logic [RegLen-1:0]  mem_sdata;
  logic [2:0]         mem_width;
  logic               mem_read_write;
  logic               mem_rdy;
  logic               mem_busy;
  logic [RegLen-1:0]  mem_ldata;

  logic [AddrLen-1:0] ram_addr;
  logic [7:0]         ram_dout;
  logic               ram_wr;
  logic [7:0]         ram_din;

  modport slave (
    input  if_needed, if_addr,
    input  mem_needed, mem_addr, mem_sdata,
    input  mem_width, mem_read_write,
    input  ram_din,
    output if_rdy, if_busy, if_data,
    output mem_rdy, mem_busy, mem_ldata,
    output ram_addr, ram_dout, ram_wr
  );

  modport master (
    output if_needed, if_addr,
    output mem_needed, mem_addr, mem_sdata,
    output mem_width, mem_read_write,
    output ram_din,
    input  if_rdy, if_busy, if_data,
    input  mem_rdy, mem_busy, mem_ldata,
    input  ram_addr, ram_dout, ram_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and MEM accesses
// onto a byte-wide RAM, one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  state_t             state_q;
  logic [2:0]         cnt_q;
  logic [2:0]         width_q;
  logic               rw_q;
  logic               who_q;
  logic [AddrLen-1:0] base_q;
  logic [RegLen-1:0]  sdata_q;
  logic [RegLen-1:0]  rbuf_q;
  logic [RegLen-1:0]  if_data_q;
  logic [RegLen-1:0]  mem_ldata_q;
  logic               if_rdy_q;
  logic               mem_rdy_q;
  logic               busy_q;
  logic [AddrLen-1:0] ram_addr_q;
  logic [7:0]         ram_dout_q;
  logic               ram_wr_q;

  logic [2:0]         cnt_d;
  logic [AddrLen-1:0] addr_d;
  logic [RegLen-1:0]  rbuf_d;

  // Next byte index, its address and read buffer with incoming byte merged.
  always_comb begin
    cnt_d  = cnt_q + 3'd1;
    addr_d = base_q + {{(AddrLen-3){1'b0}}, cnt_d};
    rbuf_d = set_byte(rbuf_q, cnt_q - 3'd1, bus.ram_din);
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      rw_q        <= 1'b0;
      who_q       <= 1'b0;
      base_q      <= '0;
      sdata_q     <= '0;
      rbuf_q      <= '0;
      if_data_q   <= '0;
      mem_ldata_q <= '0;
      if_rdy_q    <= 1'b0;
      mem_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          rbuf_q <= '0;
          if (bus.mem_needed) begin
            state_q    <= RUN;
            who_q      <= 1'b1;
            base_q     <= bus.mem_addr;
            sdata_q    <= bus.mem_sdata;
            width_q    <= norm_width(bus.mem_width);
            rw_q       <= bus.mem_read_write;
            busy_q     <= 1'b1;
            ram_addr_q <= bus.mem_addr;
            ram_wr_q   <= ~bus.mem_read_write;
            ram_dout_q <= bus.mem_read_write ?
                          8'h00 : bus.mem_sdata[7:0];
          end else if (bus.if_needed) begin
            state_q    <= RUN;
            who_q      <= 1'b0;
            base_q     <= bus.if_addr;
            sdata_q    <= '0;
            width_q    <= W_WORD;
            rw_q       <= 1'b1;
            busy_q     <= 1'b1;
            ram_addr_q <= bus.if_addr;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= '0;
          end
        end
        RUN: begin
          if (rw_q) begin
            if (cnt_q != 3'd0) rbuf_q <= rbuf_d;
            if (cnt_q == width_q) begin
              state_q    <= DONE;
              ram_addr_q <= '0;
              if (who_q) begin
                mem_ldata_q <= rbuf_d;
                mem_rdy_q   <= 1'b1;
              end else begin
                if_data_q <= rbuf_d;
                if_rdy_q  <= 1'b1;
              end
            end else begin
              cnt_q      <= cnt_d;
              ram_addr_q <= (cnt_d < width_q) ? addr_d : '0;
            end
          end else begin
            if (cnt_d == width_q) begin
              state_q    <= DONE;
              ram_addr_q <= '0;
              ram_dout_q <= '0;
              ram_wr_q   <= 1'b0;
              if (who_q) mem_rdy_q <= 1'b1;
              else       if_rdy_q  <= 1'b1;
            end else begin
              cnt_q      <= cnt_d;
              ram_addr_q <= addr_d;
              ram_dout_q <= get_byte(sdata_q, cnt_d);
            end
          end
        end
        DONE: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          if_rdy_q  <= 1'b0;
          mem_rdy_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_rdy    = if_rdy_q;
  assign bus.if_busy   = busy_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_rdy   = mem_rdy_q;
  assign bus.mem_busy  = busy_q;
  assign bus.mem_ldata = mem_ldata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// mem_ctrl testbench.
// Directed transactions against a byte RAM model.
module tb_mem_ctrl;

  logic clk;
  logic rst;

  mem_ctrl_if bus ();

  mem_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] ram [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // RAM model: registered read, write on ram_wr.
  always @(posedge clk) begin
    bus.ram_din <= rd(bus.ram_addr);
    if (bus.ram_wr) ram[bus.ram_addr] = bus.ram_dout;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic txn(
    input  bit          m,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [2:0]  w,
    input  logic        rw,
    output int          lat,
    output int          wrs,
    output bit          other
  );
    @(negedge clk);
    if (m) begin
      bus.mem_needed     = 1'b1;
      bus.mem_addr       = a;
      bus.mem_sdata      = d;
      bus.mem_width      = w;
      bus.mem_read_write = rw;
    end else begin
      bus.if_needed = 1'b1;
      bus.if_addr   = a;
    end
    lat   = 0;
    wrs   = 0;
    other = 1'b0;
    repeat (30) begin
      @(negedge clk);
      lat++;
      if (bus.ram_wr) wrs++;
      if (m ? bus.if_rdy : bus.mem_rdy) other = 1'b1;
      if (m ? bus.mem_rdy : bus.if_rdy) break;
    end
    bus.mem_needed = 1'b0;
    bus.if_needed  = 1'b0;
  endtask

  int lat;
  int wrs;
  bit other;
  bit seen;

  initial begin
    bus.if_needed      = 1'b0;
    bus.if_addr        = '0;
    bus.mem_needed     = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_sdata      = '0;
    bus.mem_width      = 3'd4;
    bus.mem_read_write = 1'b1;
    ram[32'h100]  = 8'h13;
    ram[32'h101]  = 8'h22;
    ram[32'h102]  = 8'h33;
    ram[32'h103]  = 8'h44;
    ram[32'h2003] = 8'h80;

    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_rdy", {30'd0, bus.if_rdy, bus.mem_rdy}, 32'd0);
    check("rst_busy", {30'd0, bus.if_busy, bus.mem_busy}, 32'd0);
    check("rst_ram", {bus.ram_addr[23:0], bus.ram_dout},
          32'd0);
    check("rst_wr", {31'd0, bus.ram_wr}, 32'd0);
    check("rst_data", bus.if_data | bus.mem_ldata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    txn(1'b0, 32'h100, 32'h0, 3'd4, 1'b1, lat, wrs, other);
    check("if_lat", lat, 6);
    check("if_data", bus.if_data, 32'h44332213);
    check("if_busy_done", {31'd0, bus.if_busy}, 32'd1);

    txn(1'b1, 32'h2003, 32'h0, 3'd1, 1'b1, lat, wrs, other);
    check("lb_lat", lat, 3);
    check("lb_data", bus.mem_ldata, 32'h00000080);
    check("lb_no_ifrdy", {31'd0, other}, 32'd0);
    check("if_hold", bus.if_data, 32'h44332213);

    txn(1'b1, 32'h40, 32'hDEADBEEF, 3'd4, 1'b0, lat, wrs, other);
    check("sw_lat", lat, 5);
    check("sw_wrs", wrs, 4);
    check("sw_bytes", {rd(32'h43), rd(32'h42), rd(32'h41),
          rd(32'h40)}, 32'hDEADBEEF);
    check("sw_ldata_hold", bus.mem_ldata, 32'h00000080);

    txn(1'b1, 32'h41, 32'h0, 3'd2, 1'b1, lat, wrs, other);
    check("lh_lat", lat, 4);
    check("lh_data", bus.mem_ldata, 32'h0000ADBE);

    txn(1'b1, 32'h40, 32'h0, 3'd3, 1'b1, lat, wrs, other);
    check("w3_lat", lat, 6);
    check("w3_data", bus.mem_ldata, 32'hDEADBEEF);

    txn(1'b1, 32'hFFFFFFFF, 32'h00001234, 3'd2, 1'b0,
        lat, wrs, other);
    check("wrap_wrs", wrs, 2);
    check("wrap_bytes", {16'd0, rd(32'h0), rd(32'hFFFFFFFF)},
          32'h00001234);

    @(negedge clk);
    bus.if_needed      = 1'b1;
    bus.if_addr        = 32'h100;
    bus.mem_needed     = 1'b1;
    bus.mem_addr       = 32'h2003;
    bus.mem_width      = 3'd1;
    bus.mem_read_write = 1'b1;
    lat  = 0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      lat++;
      if (!bus.if_busy || bus.if_rdy) seen = 1'b1;
      if (bus.mem_rdy) break;
    end
    bus.mem_needed = 1'b0;
    check("arb_mem_lat", lat, 3);
    check("arb_if_busy", {31'd0, seen}, 32'd0);
    check("arb_mem_data", bus.mem_ldata, 32'h00000080);
    lat = 0;
    repeat (30) begin
      @(negedge clk);
      lat++;
      if (bus.if_rdy) break;
    end
    bus.if_needed = 1'b0;
    check("arb_if_lat", lat, 7);
    check("arb_if_data", bus.if_data, 32'h44332213);

    @(negedge clk);
    bus.mem_needed     = 1'b1;
    bus.mem_addr       = 32'h80;
    bus.mem_sdata      = 32'h11223344;
    bus.mem_width      = 3'd4;
    bus.mem_read_write = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_wr_pre", {31'd0, bus.ram_wr}, 32'd1);
    rst = 1'b1;
    bus.mem_needed = 1'b0;
    #1;
    check("mid_wr_drop", {31'd0, bus.ram_wr}, 32'd0);
    check("mid_busy", {30'd0, bus.if_busy, bus.mem_busy}, 32'd0);
    check("mid_data", bus.if_data | bus.mem_ldata, 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_rdy || bus.mem_busy || bus.ram_wr) seen = 1'b1;
    end
    check("mid_quiet", {31'd0, seen}, 32'd0);
    check("mid_byte1", {24'd0, rd(32'h81)}, 32'd0);

    txn(1'b0, 32'h100, 32'h0, 3'd4, 1'b1, lat, wrs, other);
    check("post_lat", lat, 6);
    check("post_data", bus.if_data, 32'h44332213);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
